// File: rtl/sr595_frame_receiver_if.sv
// Bundle between the 595-style link / host side and the frame receiver.
// The master side drives the link pins and host controls; the slave side is the receiver.
interface sr595_frame_receiver_if #(
    parameter int SEG_CT = 8,
    parameter int CAN_CT = 8,
    parameter int CNT_W  = 16
);
    localparam int IDX_W = $clog2(CAN_CT);

    logic              en;
    logic              clr_buf;
    logic              SCLK;
    logic              DIN;
    logic              RCLK;
    logic              OE;
    logic [IDX_W-1:0]  rd_addr;
    logic [SEG_CT-1:0] rd_data;
    logic              frame_valid;
    logic              frame_err;
    logic [SEG_CT-1:0] frame_seg;
    logic [IDX_W-1:0]  frame_idx;
    logic [CNT_W-1:0]  dwell_on;
    logic [CNT_W-1:0]  dwell_tot;
    logic [IDX_W-1:0]  dwell_idx;

    modport master (
        output en, clr_buf, SCLK, DIN, RCLK, OE, rd_addr,
        input  rd_data, frame_valid, frame_err, frame_seg, frame_idx,
               dwell_on, dwell_tot, dwell_idx
    );

    modport slave (
        input  en, clr_buf, SCLK, DIN, RCLK, OE, rd_addr,
        output rd_data, frame_valid, frame_err, frame_seg, frame_idx,
               dwell_on, dwell_tot, dwell_idx
    );
endinterface

// File: rtl/sr595_frame_receiver.sv
// Receive end of the 595-style display link: rebuilds {segments, can-select} frames into a
// per-character segment buffer and measures OE-low dwell per latch period.
module sr595_frame_receiver #(
    parameter int SEG_CT      = 8,
    parameter int CAN_CT      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    sr595_frame_receiver_if.slave link
);
    localparam int IDX_W = $clog2(CAN_CT);
    localparam int FW    = SEG_CT + CAN_CT;
    localparam int BC_W  = $clog2(FW + 2);

    logic [3:0]        r_sync [SYNC_STAGES];
    logic [3:0]        r_syncD;
    logic [FW-1:0]     r_sh;
    logic [BC_W-1:0]   r_bitCnt;
    logic [SEG_CT-1:0] r_buf [CAN_CT];
    logic [SEG_CT-1:0] r_rdData;
    logic              r_frameValid;
    logic              r_frameErr;
    logic [SEG_CT-1:0] r_frameSeg;
    logic [IDX_W-1:0]  r_frameIdx;
    logic [CNT_W-1:0]  r_onCnt;
    logic [CNT_W-1:0]  r_totCnt;
    logic [CNT_W-1:0]  r_dwellOn;
    logic [CNT_W-1:0]  r_dwellTot;
    logic [IDX_W-1:0]  r_dwellIdx;

    logic [3:0]        w_q;
    logic              w_sclkRise;
    logic              w_rclkRise;
    logic              w_dinS;
    logic              w_oeS;
    logic              w_shift;
    logic              w_latch;
    logic [SEG_CT-1:0] w_seg;
    logic [CAN_CT-1:0] w_can;
    logic              w_oneHot;
    logic              w_good;
    logic [IDX_W-1:0]  w_canIdx;

    // Bit order in the sync vector: {SCLK, DIN, RCLK, OE}; all four see identical depth.
    assign w_q        = r_sync[SYNC_STAGES-1];
    assign w_sclkRise = w_q[3] & ~r_syncD[3];
    assign w_dinS     = w_q[2];
    assign w_rclkRise = w_q[1] & ~r_syncD[1];
    assign w_oeS      = w_q[0];
    assign w_shift    = w_sclkRise & link.en;
    assign w_latch    = w_rclkRise & link.en;

    assign w_seg    = r_sh[FW-1:CAN_CT];
    assign w_can    = r_sh[CAN_CT-1:0];
    assign w_oneHot = (w_can != '0) && ((w_can & (w_can - 1'b1)) == '0);
    assign w_good   = (r_bitCnt == BC_W'(FW)) && w_oneHot;

    always_comb begin
        w_canIdx = '0;
        for (int i = 0; i < CAN_CT; i++) begin
            if (w_can[i]) begin
                w_canIdx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_syncD <= '0;
        end else begin
            r_sync[0] <= {link.SCLK, link.DIN, link.RCLK, link.OE};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_syncD <= w_q;
        end
    end

    // A latch judges the pre-shift frame; a coincident shift bit starts the next frame.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            r_sh     <= '0;
            r_bitCnt <= '0;
        end else if (w_latch) begin
            if (w_shift) begin
                r_sh     <= {r_sh[FW-2:0], w_dinS};
                r_bitCnt <= BC_W'(1);
            end else begin
                r_bitCnt <= '0;
            end
        end else if (w_shift) begin
            r_sh <= {r_sh[FW-2:0], w_dinS};
            if (r_bitCnt != BC_W'(FW + 1)) begin
                r_bitCnt <= r_bitCnt + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            r_frameValid <= 1'b0;
            r_frameErr   <= 1'b0;
            r_frameSeg   <= '0;
            r_frameIdx   <= '0;
        end else begin
            r_frameValid <= w_latch & w_good;
            r_frameErr   <= w_latch & ~w_good;
            if (w_latch && w_good) begin
                r_frameSeg <= w_seg;
                r_frameIdx <= w_canIdx;
            end
        end
    end

    // Clear takes priority over a write landing in the same cycle.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CAN_CT; i++) begin
                r_buf[i] <= '0;
            end
            r_rdData <= '0;
        end else begin
            r_rdData <= r_buf[link.rd_addr];
            if (link.clr_buf) begin
                for (int i = 0; i < CAN_CT; i++) begin
                    r_buf[i] <= '0;
                end
            end else if (w_latch && w_good) begin
                r_buf[w_canIdx] <= w_seg;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            r_onCnt    <= '0;
            r_totCnt   <= '0;
            r_dwellOn  <= '0;
            r_dwellTot <= '0;
            r_dwellIdx <= '0;
        end else if (w_latch) begin
            r_dwellOn  <= r_onCnt;
            r_dwellTot <= r_totCnt;
            r_dwellIdx <= r_frameIdx;
            r_onCnt    <= w_oeS ? '0 : CNT_W'(1);
            r_totCnt   <= CNT_W'(1);
        end else begin
            if (!w_oeS && r_onCnt != '1) begin
                r_onCnt <= r_onCnt + 1'b1;
            end
            if (r_totCnt != '1) begin
                r_totCnt <= r_totCnt + 1'b1;
            end
        end
    end

    assign link.rd_data     = r_rdData;
    assign link.frame_valid = r_frameValid;
    assign link.frame_err   = r_frameErr;
    assign link.frame_seg   = r_frameSeg;
    assign link.frame_idx   = r_frameIdx;
    assign link.dwell_on    = r_dwellOn;
    assign link.dwell_tot   = r_dwellTot;
    assign link.dwell_idx   = r_dwellIdx;
endmodule

// File: tb/tb_sr595_frame_receiver.sv
// Self-checking bench for sr595_frame_receiver: frame-level reference model driven by
// directed and randomized link traffic.
module tb_sr595_frame_receiver;
    localparam int SEG_CT      = 8;
    localparam int CAN_CT      = 8;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 16;

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b0;

    sr595_frame_receiver_if #(.SEG_CT(SEG_CT), .CAN_CT(CAN_CT), .CNT_W(CNT_W)) ifc ();

    sr595_frame_receiver #(
        .SEG_CT(SEG_CT), .CAN_CT(CAN_CT), .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W)
    ) dut (
        .sys_clk(sys_clk),
        .rst_n  (rst_n),
        .link   (ifc.slave)
    );

    always #5 sys_clk = ~sys_clk;

    int vectors     = 0;
    int miscompares = 0;
    int validCount  = 0;
    int errCount    = 0;

    logic [7:0] mBuf [8];
    bit         mBits [$];
    logic [7:0] mSeg;
    logic [2:0] mIdx;

    always @(negedge sys_clk) begin
        if (ifc.frame_valid === 1'b1) validCount++;
        if (ifc.frame_err === 1'b1) errCount++;
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic modelReset();
        for (int i = 0; i < 8; i++) mBuf[i] = 8'h00;
        mBits.delete();
        mSeg = 8'h00;
        mIdx = 3'd0;
    endtask

    task automatic sendBit(input bit b, input bit useEn);
        @(negedge sys_clk);
        ifc.en  = useEn;
        ifc.DIN = b;
        idle(2);
        ifc.SCLK = 1'b1;
        idle(5);
        ifc.SCLK = 1'b0;
        idle(4);
        ifc.en = 1'b1;
        if (useEn) mBits.push_back(b);
    endtask

    task automatic sendWord(input logic [15:0] w, input int n);
        logic [16:0] ext;
        ext = {1'b1, w};
        for (int i = n - 1; i >= 0; i--) sendBit(ext[i], 1'b1);
    endtask

    task automatic latch(input bit withSclk, input bit din, input bit withClr, input bit useEn);
        int         v0, e0;
        logic [15:0] f;
        logic [7:0]  can;
        bit          good;
        int          expV, expE;
        v0 = validCount;
        e0 = errCount;
        f = 16'h0;
        foreach (mBits[i]) f = {f[14:0], mBits[i]};
        can  = f[7:0];
        good = (mBits.size() == 16) && ($countones(can) == 1);
        @(negedge sys_clk);
        ifc.en  = useEn;
        ifc.DIN = din;
        ifc.RCLK = 1'b1;
        if (withSclk) ifc.SCLK = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge sys_clk);
            if (k == SYNC_STAGES) ifc.clr_buf = withClr;
            if (k == SYNC_STAGES + 1) ifc.clr_buf = 1'b0;
            if (k == 5) begin
                ifc.RCLK = 1'b0;
                ifc.SCLK = 1'b0;
            end
        end
        ifc.en = 1'b1;
        if (useEn) begin
            if (good) begin
                mSeg = f[15:8];
                for (int i = 0; i < 8; i++) if (can[i]) mIdx = 3'(i);
                mBuf[mIdx] = mSeg;
            end
            mBits.delete();
            if (withSclk) mBits.push_back(din);
        end else if (withSclk) begin
            mBits.push_back(din);
            mBits.pop_back();
        end
        if (withClr) for (int i = 0; i < 8; i++) mBuf[i] = 8'h00;
        expV = (useEn && good) ? 1 : 0;
        expE = (useEn && !good) ? 1 : 0;
        vectors += 4;
        if ((validCount - v0) !== expV) begin
            miscompares++;
            $display("[TB] FAIL valid_pulses: got %0d expected %0d", validCount - v0, expV);
        end
        if ((errCount - e0) !== expE) begin
            miscompares++;
            $display("[TB] FAIL err_pulses: got %0d expected %0d", errCount - e0, expE);
        end
        if (ifc.frame_seg !== mSeg) begin
            miscompares++;
            $display("[TB] FAIL frame_seg: got %0h expected %0h", ifc.frame_seg, mSeg);
        end
        if (ifc.frame_idx !== mIdx) begin
            miscompares++;
            $display("[TB] FAIL frame_idx: got %0d expected %0d", ifc.frame_idx, mIdx);
        end
    endtask

    task automatic checkBuffer();
        for (int a = 0; a < 8; a++) begin
            @(negedge sys_clk);
            ifc.rd_addr = 3'(a);
            @(negedge sys_clk);
            vectors++;
            if (ifc.rd_data !== mBuf[a]) begin
                miscompares++;
                $display("[TB] FAIL rd_data[%0d]: got %0h expected %0h", a, ifc.rd_data, mBuf[a]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge sys_clk);
            ifc.SCLK = 1'($urandom);
            ifc.DIN  = 1'($urandom);
            ifc.RCLK = 1'($urandom);
            ifc.OE   = 1'($urandom);
        end
        ifc.SCLK = 1'b0;
        ifc.DIN  = 1'b0;
        ifc.RCLK = 1'b0;
        ifc.OE   = 1'b1;
        idle(3);
        vectors++;
        if ({ifc.frame_valid, ifc.frame_err, ifc.frame_seg, ifc.frame_idx, ifc.rd_data,
             ifc.dwell_on, ifc.dwell_tot, ifc.dwell_idx} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got seg=%0h idx=%0d on=%0d tot=%0d rd=%0h expected all 0",
                     ifc.frame_seg, ifc.frame_idx, ifc.dwell_on, ifc.dwell_tot, ifc.rd_data);
        end
        rst_n = 1'b1;
        modelReset();
        idle(4);
        checkBuffer();
    endtask

    task automatic test_basic();
        sendWord(16'hA504, 16);
        latch(1'b0, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (ifc.frame_idx !== 3'd2 || ifc.frame_seg !== 8'hA5) begin
            miscompares++;
            $display("[TB] FAIL basic_frame: got seg=%0h idx=%0d expected seg=a5 idx=2",
                     ifc.frame_seg, ifc.frame_idx);
        end
        checkBuffer();
    endtask

    task automatic test_bad_length();
        sendWord(16'h1234, 15);
        latch(1'b0, 1'b0, 1'b0, 1'b1);
        sendWord(16'h5610, 17);
        latch(1'b0, 1'b0, 1'b0, 1'b1);
        sendWord(16'h3C80, 16);
        latch(1'b0, 1'b0, 1'b0, 1'b1);
        checkBuffer();
    endtask

    task automatic test_bad_can();
        sendWord(16'h5506, 16);
        latch(1'b0, 1'b0, 1'b0, 1'b1);
        sendWord(16'h5500, 16);
        latch(1'b0, 1'b0, 1'b0, 1'b1);
        checkBuffer();
    endtask

    task automatic test_dwell();
        logic [2:0] prevIdx;
        prevIdx = mIdx;
        sendWord(16'hFF01, 16);
        latch(1'b0, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (ifc.dwell_idx !== prevIdx) begin
            miscompares++;
            $display("[TB] FAIL dwell_idx_prev: got %0d expected %0d", ifc.dwell_idx, prevIdx);
        end
        @(negedge sys_clk);
        ifc.OE = 1'b0;
        idle(100);
        ifc.OE = 1'b1;
        idle(288);
        latch(1'b0, 1'b0, 1'b0, 1'b1);
        vectors += 3;
        if (ifc.dwell_on < 99 || ifc.dwell_on > 101) begin
            miscompares++;
            $display("[TB] FAIL dwell_on: got %0d expected 100 (+/-1)", ifc.dwell_on);
        end
        if (ifc.dwell_tot < 399 || ifc.dwell_tot > 401) begin
            miscompares++;
            $display("[TB] FAIL dwell_tot: got %0d expected 400 (+/-1)", ifc.dwell_tot);
        end
        if (ifc.dwell_idx !== 3'd0) begin
            miscompares++;
            $display("[TB] FAIL dwell_idx: got %0d expected 0", ifc.dwell_idx);
        end
    endtask

    task automatic test_enable();
        logic [15:0] w;
        w = 16'h1208;
        for (int i = 15; i >= 8; i--) sendBit(w[i], 1'b1);
        for (int i = 0; i < 5; i++) sendBit(1'($urandom), 1'b0);
        for (int i = 7; i >= 0; i--) sendBit(w[i], 1'b1);
        latch(1'b0, 1'b0, 1'b0, 1'b0);
        latch(1'b0, 1'b0, 1'b0, 1'b1);
        checkBuffer();
    endtask

    task automatic test_back_to_back();
        sendWord(16'h6610, 16);
        latch(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 14; i >= 0; i--) sendBit(1'((16'h9920 >> i) & 16'h1), 1'b1);
        latch(1'b0, 1'b0, 1'b0, 1'b1);
        checkBuffer();
        sendWord(16'h4240, 16);
        latch(1'b0, 1'b0, 1'b1, 1'b1);
        checkBuffer();
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            logic [7:0] seg, can;
            int len;
            seg = 8'($urandom);
            can = ($urandom_range(0, 9) < 7) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
            case ($urandom_range(0, 9))
                0: len = 15;
                1: len = 17;
                default: len = 16;
            endcase
            sendWord({seg, can}, len);
            latch(1'b0, 1'b0, ($urandom_range(0, 9) == 0), 1'b1);
        end
        checkBuffer();
    endtask

    initial begin
        ifc.en      = 1'b1;
        ifc.clr_buf = 1'b0;
        ifc.SCLK    = 1'b0;
        ifc.DIN     = 1'b0;
        ifc.RCLK    = 1'b0;
        ifc.OE      = 1'b1;
        ifc.rd_addr = 3'd0;
        modelReset();
        test_reset();
        test_basic();
        test_bad_length();
        test_bad_can();
        test_dwell();
        test_enable();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
